// File: rtl/duty_ramp_ctrl_if.sv
// Target-duty handshake between a duty requester and duty_ramp_ctrl.
// valid/ready: a target transfers on any clock edge where target_vld && target_rdy are both high.
interface duty_ramp_ctrl_if;
    logic [9:0] target;
    logic       target_vld;
    logic       target_rdy;

    modport master (output target, output target_vld, input target_rdy);
    modport slave  (input target, input target_vld, output target_rdy);
endinterface

// File: rtl/duty_ramp_ctrl.sv
// Slew-limited duty source for a 10-bit PWM: ramps duty toward a requested target,
// changing it only at PWM period boundaries, with a latched fault brake.
module duty_ramp_ctrl #(
    parameter int STEP     = 8,
    parameter int RAMP_DIV = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   fault,
    duty_ramp_ctrl_if.slave        tgt_bus,
    output logic [9:0]             duty,
    output logic                   at_target,
    output logic [1:0]             state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RAMP  = 2'b01,
        HOLD  = 2'b10,
        BRAKE = 2'b11
    } state_t;

    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [9:0]  STEP_D   = 10'(STEP);
    localparam logic [7:0]  DIV_LAST = 8'(RAMP_DIV - 1);

    state_t      state, state_nx;
    logic [9:0]  cnt;
    logic [9:0]  tgt, tgt_nx, tgt_eff, duty_nx;
    logic [7:0]  div, div_nx;
    logic [10:0] gap;
    logic        tick, update, accept;

    // Period counter runs in lockstep with the PWM counter; tick marks its last count.
    assign tick      = (cnt == 10'h3FF);
    assign tgt_eff   = en ? tgt : 10'd0;
    assign tgt_bus.target_rdy = (state != BRAKE);
    assign accept    = tgt_bus.target_vld && tgt_bus.target_rdy;
    assign update    = (state == RAMP) && tick && (div == DIV_LAST);
    assign at_target = (duty == tgt_eff) && (state != BRAKE);
    assign state_o   = state;

    always_comb begin
        gap = 11'd0;
        if (duty < tgt_eff) gap = {1'b0, tgt_eff} - {1'b0, duty};
        else                gap = {1'b0, duty} - {1'b0, tgt_eff};
    end

    always_comb begin
        state_nx = state;
        duty_nx  = duty;
        tgt_nx   = tgt;
        div_nx   = div;

        if (accept) tgt_nx = tgt_bus.target;

        // A remaining gap within one step lands exactly on the target, so no overshoot or wrap.
        if (update) begin
            if (gap <= STEP_W)       duty_nx = tgt_eff;
            else if (duty < tgt_eff) duty_nx = duty + STEP_D;
            else                     duty_nx = duty - STEP_D;
        end

        if (state == RAMP) begin
            if (tick) div_nx = (div == DIV_LAST) ? 8'd0 : div + 8'd1;
        end else begin
            div_nx = 8'd0;
        end

        case (state)
            IDLE:    if (en && (tgt != 10'd0)) state_nx = RAMP;
            RAMP:    if (duty == tgt_eff) state_nx = en ? HOLD : IDLE;
            HOLD:    if (duty != tgt_eff) state_nx = RAMP;
            BRAKE:   if (!fault && !en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        // Fault overrides everything, including a target arriving in the same cycle.
        if (fault) begin
            state_nx = BRAKE;
            duty_nx  = 10'd0;
            tgt_nx   = 10'd0;
            div_nx   = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 10'd0;
            div   <= 8'd0;
            tgt   <= 10'd0;
            duty  <= 10'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt + 10'd1;
            div   <= div_nx;
            tgt   <= tgt_nx;
            duty  <= duty_nx;
        end
    end

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl: three instances (step 8 / div 1, step 8 / div 4,
// step 340 / div 1) checked against hand-computed duty sequences at period boundaries.
module tb_duty_ramp_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic en_a, en_d, en_w;
    logic fault_a, fault_d, fault_w;
    logic [9:0] duty_a, duty_d, duty_w;
    logic at_a, at_d, at_w;
    logic [1:0] state_a, state_d, state_w;
    logic [9:0] tb_cnt;
    int tests;
    int fails;

    duty_ramp_ctrl_if bus_a ();
    duty_ramp_ctrl_if bus_d ();
    duty_ramp_ctrl_if bus_w ();

    duty_ramp_ctrl #(.STEP(8), .RAMP_DIV(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .fault(fault_a), .tgt_bus(bus_a.slave),
        .duty(duty_a), .at_target(at_a), .state_o(state_a)
    );

    duty_ramp_ctrl #(.STEP(8), .RAMP_DIV(4)) u_dut_d (
        .clk(clk), .rst_n(rst_n), .en(en_d), .fault(fault_d), .tgt_bus(bus_d.slave),
        .duty(duty_d), .at_target(at_d), .state_o(state_d)
    );

    duty_ramp_ctrl #(.STEP(340), .RAMP_DIV(1)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .en(en_w), .fault(fault_w), .tgt_bus(bus_w.slave),
        .duty(duty_w), .at_target(at_w), .state_o(state_w)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Bench-side period counter: models the PWM period position independently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= 10'd0;
        else        tb_cnt <= tb_cnt + 10'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cnt(input logic [9:0] val);
        int n;
        n = 0;
        @(negedge clk);
        while (tb_cnt != val && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("wait_cnt", 32'(tb_cnt), 32'(val));
    endtask

    initial begin
        int exp_a;
        int exp_w;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        en_a = 1'b1; en_d = 1'b1; en_w = 1'b1;
        fault_a = 1'b0; fault_d = 1'b0; fault_w = 1'b0;
        bus_a.target = '0; bus_a.target_vld = 1'b0;
        bus_d.target = '0; bus_d.target_vld = 1'b0;
        bus_w.target = '0; bus_w.target_vld = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_duty", 32'(duty_a), 0);
        check("rst_state", 32'(state_a), 0);
        check("rst_rdy", 32'(bus_a.target_rdy), 1);
        check("rst_at_target", 32'(at_a), 1);
        check("rst_duty_w", 32'(duty_w), 0);
        rst_n = 1'b1;

        // ramp up: 100 on a, 16 on d (divided), 1020 on w
        @(negedge clk);
        bus_a.target = 10'd100;  bus_a.target_vld = 1'b1;
        bus_d.target = 10'd16;   bus_d.target_vld = 1'b1;
        bus_w.target = 10'd1020; bus_w.target_vld = 1'b1;
        @(negedge clk);
        bus_a.target_vld = 1'b0; bus_d.target_vld = 1'b0; bus_w.target_vld = 1'b0;
        @(negedge clk);
        check("up_state_ramp", 32'(state_a), 1);
        check("up_not_at_target", 32'(at_a), 0);
        for (int k = 1; k <= 13; k++) begin
            wait_cnt(10'd0);
            exp_a = (8 * k > 100) ? 100 : 8 * k;
            check("up_duty_a", 32'(duty_a), 32'(exp_a));
            if (k <= 8) check("div4_duty_d", 32'(duty_d), 32'((k / 4) * 8));
            if (k <= 4) begin
                exp_w = (340 * k > 1020) ? 1020 : 340 * k;
                check("up_duty_w", 32'(duty_w), 32'(exp_w));
            end
        end
        @(negedge clk);
        @(negedge clk);
        check("up_hold_a", 32'(state_a), 2);
        check("up_at_target_a", 32'(at_a), 1);
        check("div4_hold_d", 32'(state_d), 2);
        check("div4_final_d", 32'(duty_d), 16);
        check("up_hold_w", 32'(state_w), 2);

        // ramp down a to 40; w to top-of-range 1023 then down to 5
        bus_a.target = 10'd40;   bus_a.target_vld = 1'b1;
        bus_w.target = 10'd1023; bus_w.target_vld = 1'b1;
        @(negedge clk);
        bus_a.target_vld = 1'b0; bus_w.target_vld = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            wait_cnt(10'd0);
            exp_a = (k == 8) ? 40 : 100 - 8 * k;
            check("down_duty_a", 32'(duty_a), 32'(exp_a));
            if (k == 1) begin
                check("top_clamp_w", 32'(duty_w), 1023);
                bus_w.target = 10'd5; bus_w.target_vld = 1'b1;
                @(negedge clk);
                bus_w.target_vld = 1'b0;
            end else if (k <= 4) begin
                exp_w = (k == 2) ? 683 : ((k == 3) ? 343 : 5);
                check("down_duty_w", 32'(duty_w), 32'(exp_w));
            end
        end
        @(negedge clk);
        @(negedge clk);
        check("down_hold_a", 32'(state_a), 2);
        check("down_final_a", 32'(duty_a), 40);
        check("down_at_target_a", 32'(at_a), 1);
        check("down_hold_w", 32'(state_w), 2);

        // soft stop on w; a ramps back up toward 100 before a fault
        en_w = 1'b0;
        @(negedge clk);
        check("stop_state_w", 32'(state_w), 1);
        check("stop_at_target_w", 32'(at_w), 0);
        bus_a.target = 10'd100; bus_a.target_vld = 1'b1;
        @(negedge clk);
        bus_a.target_vld = 1'b0;
        wait_cnt(10'd0);
        check("refill_duty_a", 32'(duty_a), 48);
        check("stop_duty_w", 32'(duty_w), 0);
        wait_cnt(10'd0);
        check("refill_duty_a2", 32'(duty_a), 56);
        check("stop_idle_w", 32'(state_w), 0);

        // fault mid-period, same cycle as a valid target
        wait_cnt(10'h123);
        fault_a = 1'b1;
        bus_a.target = 10'd200; bus_a.target_vld = 1'b1;
        @(negedge clk);
        check("fault_duty", 32'(duty_a), 0);
        check("fault_state", 32'(state_a), 3);
        check("fault_rdy", 32'(bus_a.target_rdy), 0);
        check("fault_at_target", 32'(at_a), 0);
        fault_a = 1'b0;
        bus_a.target = 10'd300;
        repeat (3) @(negedge clk);
        check("brake_stays", 32'(state_a), 3);
        bus_a.target_vld = 1'b0;
        en_a = 1'b0;
        @(negedge clk);
        check("brake_release", 32'(state_a), 0);
        en_a = 1'b1;
        repeat (2) @(negedge clk);
        check("brake_tgt_cleared", 32'(state_a), 0);
        check("brake_duty_zero", 32'(duty_a), 0);
        check("brake_rdy_back", 32'(bus_a.target_rdy), 1);

        // async reset mid-ramp
        bus_a.target = 10'd100; bus_a.target_vld = 1'b1;
        @(negedge clk);
        bus_a.target_vld = 1'b0;
        wait_cnt(10'd0);
        check("pre_rst_duty", 32'(duty_a), 8);
        wait_cnt(10'd0);
        check("pre_rst_duty2", 32'(duty_a), 16);
        wait_cnt(10'h200);
        rst_n = 1'b0;
        #1;
        check("async_rst_duty", 32'(duty_a), 0);
        check("async_rst_state", 32'(state_a), 0);
        check("async_rst_rdy", 32'(bus_a.target_rdy), 1);
        check("async_rst_at_target", 32'(at_a), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // target handed over on the update edge: the step still uses the old target
        @(negedge clk);
        bus_a.target = 10'd100; bus_a.target_vld = 1'b1;
        @(negedge clk);
        bus_a.target_vld = 1'b0;
        wait_cnt(10'd0);
        check("post_rst_duty", 32'(duty_a), 8);
        wait_cnt(10'h3FF);
        bus_a.target = 10'd12; bus_a.target_vld = 1'b1;
        @(negedge clk);
        bus_a.target_vld = 1'b0;
        check("edge_old_tgt", 32'(duty_a), 16);
        wait_cnt(10'd0);
        check("edge_new_tgt", 32'(duty_a), 12);
        @(negedge clk);
        @(negedge clk);
        check("edge_hold", 32'(state_a), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
